// File: rtl/ram4096x16_pkg.sv
// Shared definitions for the ram4096X16 bus master: RAM geometry, controller
// FSM state encoding and the rw pin levels.
package ram4096x16_pkg;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO; the head entry is visible on dout while not empty,
// and a written entry becomes visible on the edge after the push.
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 29
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ram4096x16_ctrl.sv
// Bus master for ram4096X16: queues user requests and sequences them in order
// onto the RAM's shared rw/addr/data port, returning read data as a pulse.
module ram4096x16_ctrl #(
    parameter int AW     = ram4096x16_pkg::AW,
    parameter int DW     = ram4096x16_pkg::DW,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data
);

    import ram4096x16_pkg::state_t;
    import ram4096x16_pkg::IDLE;
    import ram4096x16_pkg::WR;
    import ram4096x16_pkg::RD;
    import ram4096x16_pkg::RW_WRITE;
    import ram4096x16_pkg::RW_READ;

    localparam int FW = 1 + AW + DW;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rw_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic          rsp_valid_n;
    logic [DW-1:0] rsp_data_n;
    logic          take;

    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic          head_we;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_wdata;

    assign req_ready = rst_n && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_din  = {req_we, req_addr, req_wdata};
    assign {head_we, head_addr, head_wdata} = fifo_dout;

    req_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (take),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The registered rw doubles as the drive enable, so the RAM and the
    // controller can never both own the bus in the same cycle.
    assign ram_data = (ram_rw == RW_WRITE) ? wdata_q : {DW{1'bz}};
    assign busy     = !fifo_empty || (state != IDLE);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rw_n        = ram_rw;
        addr_n      = ram_addr;
        wdata_n     = wdata_q;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        take        = 1'b0;

        case (state)
            IDLE: take = !fifo_empty;
            WR: begin
                take = !fifo_empty;
                if (fifo_empty) begin
                    rw_n    = RW_READ;
                    state_n = IDLE;
                end
            end
            RD: begin
                if (cnt == CW'(RD_LAT - 1)) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = ram_data;
                    take        = !fifo_empty;
                    if (fifo_empty) state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Launching the next request straight from WR/RD avoids any bubble
        // when switching direction.
        if (take) begin
            addr_n = head_addr;
            if (head_we) begin
                rw_n    = RW_WRITE;
                wdata_n = head_wdata;
                state_n = WR;
            end else begin
                rw_n    = RW_READ;
                cnt_n   = '0;
                state_n = RD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_rw    <= RW_READ;
            ram_addr  <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ram_rw    <= rw_n;
            ram_addr  <= addr_n;
            wdata_q   <= wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
        end
    end

endmodule
